// File: rtl/imm_encoder_if.sv
// Request/result stream bundle for the immediate encoder.
// The master side issues templates and immediates and consumes encoded words.
// The slave side is the encoder itself.
interface imm_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_tmpl;
    logic [63:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;

    modport master (
        output in_valid, in_tmpl, in_imm, out_ready,
        input  in_ready, out_valid, out_inst, out_err
    );

    modport slave (
        input  in_valid, in_tmpl, in_imm, out_ready,
        output in_ready, out_valid, out_inst, out_err
    );
endinterface

// File: rtl/imm_encoder.sv
// Streaming immediate encoder: inserts a signed immediate into the immediate
// fields of a 32-bit instruction template (format chosen by template [6:5]).
// Two registered stages with valid/ready stalling, a range/format error flag
// and saturating counters of delivered good and bad results.
module imm_encoder #(
    parameter int CNT_W    = 16,
    parameter bit ERR_ZERO = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    imm_encoder_if.slave     bus,
    output logic [CNT_W-1:0] cnt_ok,
    output logic [CNT_W-1:0] cnt_err
);

    // Stage 1: captured request
    logic        s1_valid_q;
    logic [31:0] s1_tmpl_q;
    logic [11:0] s1_imm_q;
    logic        s1_err_q;

    // Stage 2: encoded result
    logic        s2_valid_q;
    logic [31:0] out_inst_q;
    logic        out_err_q;

    logic [CNT_W-1:0] cnt_ok_q;
    logic [CNT_W-1:0] cnt_err_q;

    logic        adv1;
    logic        adv2;
    logic        range_ok;
    logic        s1_err_d;
    logic [11:0] v_ins;
    logic [31:0] inst_d;
    logic        out_hs;

    // A stage may load when it is empty or its content moves on this cycle.
    assign adv2   = !s2_valid_q || bus.out_ready;
    assign adv1   = !s1_valid_q || adv2;
    assign out_hs = s2_valid_q && bus.out_ready;

    // The 12-bit field holds the value only if bits 63..11 are a pure sign extension.
    assign range_ok = (&bus.in_imm[63:11]) || !(|bus.in_imm[63:11]);
    assign s1_err_d = !range_ok || (bus.in_tmpl[6:5] == 2'b11);

    // Scatter the 12-bit immediate into the fields of the selected format.
    always_comb begin
        v_ins  = (s1_err_q && (ERR_ZERO == 1'b1)) ? 12'd0 : s1_imm_q;
        inst_d = s1_tmpl_q;
        case (s1_tmpl_q[6:5])
            2'b00: begin
                inst_d[31:20] = v_ins;
            end
            2'b01: begin
                inst_d[31:25] = v_ins[11:5];
                inst_d[11:7]  = v_ins[4:0];
            end
            2'b10: begin
                inst_d[31]    = v_ins[11];
                inst_d[7]     = v_ins[10];
                inst_d[30:25] = v_ins[9:4];
                inst_d[11:8]  = v_ins[3:0];
            end
            default: begin
                inst_d = s1_tmpl_q;
            end
        endcase
    end

    // Stage 1 register: accept a new request whenever the pipe can advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_tmpl_q  <= 32'd0;
            s1_imm_q   <= 12'd0;
            s1_err_q   <= 1'b0;
        end else if (adv1) begin
            s1_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                s1_tmpl_q <= bus.in_tmpl;
                s1_imm_q  <= bus.in_imm[11:0];
                s1_err_q  <= s1_err_d;
            end
        end
    end

    // Stage 2 register: result is frozen while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            out_inst_q <= 32'd0;
            out_err_q  <= 1'b0;
        end else if (adv2) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_inst_q <= inst_d;
                out_err_q  <= s1_err_q;
            end
        end
    end

    // Saturating tallies of delivered results, split by error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_ok_q  <= '0;
            cnt_err_q <= '0;
        end else if (out_hs) begin
            if (!out_err_q) begin
                if (!(&cnt_ok_q)) cnt_ok_q <= cnt_ok_q + CNT_W'(1);
            end else begin
                if (!(&cnt_err_q)) cnt_err_q <= cnt_err_q + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready  = adv1;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_inst  = out_inst_q;
    assign bus.out_err   = out_err_q;
    assign cnt_ok        = cnt_ok_q;
    assign cnt_err       = cnt_err_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed vector table, backpressure, mid-stream
// reset and a random stream checked by decoding results back to immediates.
module tb_imm_encoder;
    localparam int CNT_W = 5;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [CNT_W-1:0] cnt_ok;
    logic [CNT_W-1:0] cnt_err;

    imm_encoder_if bus();

    imm_encoder #(.CNT_W(CNT_W), .ERR_ZERO(1'b1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .cnt_ok  (cnt_ok),
        .cnt_err (cnt_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] tmpl;
        logic [63:0] imm;
        logic [31:0] inst;
        logic        err;
    } vec_t;

    typedef struct {
        logic [31:0] tmpl;
        logic [63:0] imm;
    } req_t;

    int     checks = 0;
    int     errors = 0;
    int     exp_ok = 0;
    int     exp_err = 0;
    int     rcv = 0;
    req_t   sb[$];
    bit     stall_prev = 1'b0;
    logic [31:0] prev_inst;
    vec_t   vecs[14];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int sat_inc(input int x);
        return (x >= CMAX) ? CMAX : x + 1;
    endfunction

    // Bits of the word that carry the immediate for each format.
    function automatic logic [31:0] fmask(input logic [1:0] f);
        case (f)
            2'b00:   return 32'hFFF0_0000;
            2'b01:   return 32'hFE00_0F80;
            2'b10:   return 32'hFE00_0F80;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // Core decode rule, sign-extended to 64 bits.
    function automatic logic [63:0] decode(input logic [31:0] i, input logic [1:0] f);
        logic [11:0] v;
        case (f)
            2'b00:   v = i[31:20];
            2'b01:   v = {i[31:25], i[11:7]};
            2'b10:   v = {i[31], i[7], i[30:25], i[11:8]};
            default: v = 12'd0;
        endcase
        return {{52{v[11]}}, v};
    endfunction

    function automatic bit exp_err_f(input logic [31:0] t, input logic [63:0] imm);
        longint s;
        s = imm;
        return (t[6:5] == 2'b11) || (s < -2048) || (s > 2047);
    endfunction

    function automatic logic [63:0] gen_imm();
        longint s;
        case ($urandom_range(0, 5))
            0, 1: s = longint'($urandom_range(0, 4095)) - 2048;
            2: begin
                case ($urandom_range(0, 3))
                    0:       s = 2047;
                    1:       s = -2048;
                    2:       s = 2048;
                    default: s = -2049;
                endcase
            end
            3:       s = {$urandom, $urandom};
            4:       s = longint'($urandom_range(0, 8191)) - 4096;
            default: s = -longint'($urandom_range(0, 3));
        endcase
        return s;
    endfunction

    // One cycle of streaming, entered and left at a falling edge.
    task automatic stream_cycle(input bit rdy, input bit have, input logic [31:0] t,
                                input logic [63:0] im, output bit fired);
        req_t        e;
        bit          ee;
        bit          good;
        logic [31:0] m;
        bus.out_ready = rdy;
        bus.in_valid  = have;
        bus.in_tmpl   = t;
        bus.in_imm    = im;
        #1;
        if (stall_prev) begin
            chk("hold_valid", bus.out_valid, 1'b1);
            chk("hold_inst", bus.out_inst, prev_inst);
        end
        stall_prev = bus.out_valid && !bus.out_ready;
        prev_inst  = bus.out_inst;
        if (bus.out_valid && bus.out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL stream_extra: got inst 0x%08h with nothing outstanding, required no output",
                         bus.out_inst);
            end else begin
                e  = sb.pop_front();
                ee = exp_err_f(e.tmpl, e.imm);
                m  = fmask(e.tmpl[6:5]);
                if (ee)
                    good = (bus.out_err == 1'b1) && (bus.out_inst == (e.tmpl & ~m));
                else
                    good = (bus.out_err == 1'b0) && (decode(bus.out_inst, e.tmpl[6:5]) == e.imm)
                           && ((bus.out_inst & ~m) == (e.tmpl & ~m));
                if (!good) begin
                    errors++;
                    $display("FAIL stream_result: tmpl=0x%08h imm=0x%016h got inst=0x%08h err=%0b required err=%0b",
                             e.tmpl, e.imm, bus.out_inst, bus.out_err, ee);
                end else begin
                    $display("rx %0d tmpl=0x%08h imm=0x%016h inst=0x%08h err=%0b",
                             rcv, e.tmpl, e.imm, bus.out_inst, bus.out_err);
                end
                if (ee) exp_err = sat_inc(exp_err);
                else    exp_ok  = sat_inc(exp_ok);
            end
            rcv++;
        end
        fired = bus.in_valid && bus.in_ready;
        if (fired) sb.push_back('{t, im});
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          f;
        int          sent;
        logic [31:0] bp_t[4];
        logic [63:0] bp_i[4];
        logic [31:0] rt;
        logic [63:0] ri;
        localparam int NRAND = 1500;

        vecs[0]  = '{32'h0000_0013, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFF0_0013, 1'b0};
        vecs[1]  = '{32'h0000_2023, 64'h0000_0000_0000_0123, 32'h1200_21A3, 1'b0};
        vecs[2]  = '{32'h0000_0043, 64'hFFFF_FFFF_FFFF_F800, 32'h8000_0043, 1'b0};
        vecs[3]  = '{32'h0000_0043, 64'h0000_0000_0000_0400, 32'h0000_00C3, 1'b0};
        vecs[4]  = '{32'h0000_0013, 64'h0000_0000_0000_0800, 32'h0000_0013, 1'b1};
        vecs[5]  = '{32'h0000_006F, 64'h0000_0000_0000_0000, 32'h0000_006F, 1'b1};
        vecs[6]  = '{32'h0000_0063, 64'h0000_0000_0000_0010, 32'h0000_0063, 1'b1};
        vecs[7]  = '{32'h0000_0013, 64'h0000_0000_0000_07FF, 32'h7FF0_0013, 1'b0};
        vecs[8]  = '{32'h0000_0013, 64'hFFFF_FFFF_FFFF_F7FF, 32'h0000_0013, 1'b1};
        vecs[9]  = '{32'hFE00_2FA3, 64'h8000_0000_0000_0000, 32'h0000_2023, 1'b1};
        vecs[10] = '{32'h0000_2023, 64'hFFFF_FFFF_FFFF_F800, 32'h8000_2023, 1'b0};
        vecs[11] = '{32'h0000_0043, 64'hFFFF_FFFF_FFFF_FFFE, 32'hFE00_0EC3, 1'b0};
        vecs[12] = '{32'hFFF0_0013, 64'h0000_0000_0000_0005, 32'h0050_0013, 1'b0};
        vecs[13] = '{32'hFFF0_0013, 64'h0000_0000_0000_1000, 32'h0000_0013, 1'b1};

        bus.in_valid  = 1'b0;
        bus.in_tmpl   = 32'd0;
        bus.in_imm    = 64'd0;
        bus.out_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_inst", bus.out_inst, 32'd0);
        chk("rst_out_err", bus.out_err, 1'b0);
        chk("rst_cnt_ok", cnt_ok, 0);
        chk("rst_cnt_err", cnt_err, 0);
        #5 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1'b1);

        // Directed table, one request at a time, consumer always ready
        bus.out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            bus.in_valid = 1'b1;
            bus.in_tmpl  = vecs[i].tmpl;
            bus.in_imm   = vecs[i].imm;
            @(posedge clk);
            #1 bus.in_valid = 1'b0;
            @(negedge clk);
            chk("vec_lat_valid", bus.out_valid, 1'b0);
            @(negedge clk);
            chk("vec_valid", bus.out_valid, 1'b1);
            chk("vec_inst", bus.out_inst, vecs[i].inst);
            chk("vec_err", bus.out_err, vecs[i].err);
            $display("vec %0d tmpl=0x%08h imm=0x%016h inst=0x%08h err=%0b",
                     i, vecs[i].tmpl, vecs[i].imm, bus.out_inst, bus.out_err);
            if (vecs[i].err) exp_err = sat_inc(exp_err);
            else             exp_ok  = sat_inc(exp_ok);
        end
        @(negedge clk);
        chk("vec_cnt_ok", cnt_ok, exp_ok);
        chk("vec_cnt_err", cnt_err, exp_err);
        chk("vec_cnt_ok_8", cnt_ok, 8);
        chk("vec_cnt_err_6", cnt_err, 6);

        // Backpressure: 4 back-to-back requests, consumer stalled at first
        bp_t[0] = 32'h0000_0013; bp_i[0] = 64'd1;
        bp_t[1] = 32'h0000_2023; bp_i[1] = 64'hFFFF_FFFF_FFFF_FFFB;
        bp_t[2] = 32'h0000_0043; bp_i[2] = 64'd100;
        bp_t[3] = 32'h0000_0013; bp_i[3] = 64'hFFFF_FFFF_FFFF_F800;
        sent = 0;
        rcv  = 0;
        for (int c = 0; c < 60 && rcv < 4; c++) begin
            if (c == 5) chk("bp_accepted_before_ready", sent, 2);
            stream_cycle(c >= 5, sent < 4, bp_t[sent & 3], bp_i[sent & 3], f);
            if (f) sent++;
        end
        if (rcv < 4) begin
            errors++;
            $display("FAIL bp_timeout: got %0d results required 4", rcv);
        end
        chk("bp_cnt_ok", cnt_ok, exp_ok);
        chk("bp_cnt_err", cnt_err, exp_err);

        // Reset with both stages full
        stream_cycle(1'b0, 1'b1, 32'h0000_0013, 64'd7, f);
        stream_cycle(1'b0, 1'b1, 32'h0000_0013, 64'd8, f);
        bus.in_valid = 1'b0;
        #1;
        chk("mid_full_valid", bus.out_valid, 1'b1);
        chk("mid_full_in_ready", bus.in_ready, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", bus.out_valid, 1'b0);
        chk("mid_rst_inst", bus.out_inst, 32'd0);
        chk("mid_rst_cnt_ok", cnt_ok, 0);
        chk("mid_rst_cnt_err", cnt_err, 0);
        sb.delete();
        exp_ok     = 0;
        exp_err    = 0;
        stall_prev = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", bus.in_ready, 1'b1);
        chk("post_rst_valid", bus.out_valid, 1'b0);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_tmpl   = 32'h0000_2023;
        bus.in_imm    = 64'h123;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_lat1", bus.out_valid, 1'b0);
        @(negedge clk);
        chk("post_rst_lat2", bus.out_valid, 1'b1);
        chk("post_rst_inst", bus.out_inst, 32'h1200_21A3);
        chk("post_rst_err", bus.out_err, 1'b0);
        $display("post-reset tmpl=0x00002023 imm=0x123 inst=0x%08h err=%0b", bus.out_inst, bus.out_err);
        exp_ok = sat_inc(exp_ok);
        @(negedge clk);
        chk("post_rst_cnt_ok", cnt_ok, exp_ok);

        // Random stream with random backpressure; counters saturate here
        sent = 0;
        rcv  = 0;
        for (int c = 0; c < NRAND * 12 && rcv < NRAND; c++) begin
            rt = $urandom;
            ri = gen_imm();
            stream_cycle($urandom_range(0, 3) != 0, (sent < NRAND) && ($urandom_range(0, 4) != 0), rt, ri, f);
            if (f) sent++;
        end
        if (rcv < NRAND) begin
            errors++;
            $display("FAIL rand_timeout: got %0d results required %0d", rcv, NRAND);
        end
        bus.in_valid = 1'b0;
        chk("rand_cnt_ok", cnt_ok, exp_ok);
        chk("rand_cnt_err", cnt_err, exp_err);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
